// File: rtl/complex_result_collector.sv
// Reassembles U-element result chunks from the matrix-by-vector decoder into an N-element vector.
// Optional feature macro: COLLECTOR_PAD_CHECK_EN (flags nonzero data in discarded padding slots).
module complex_result_collector #(
  parameter int no_of_eqn_per_cluster = 3,
  parameter int element_width         = 64,
  parameter int no_of_units           = 4,
  parameter int NI                    = 8
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic [element_width*no_of_units-1:0]       in_data,
  input  logic                                       in_valid,
  output logic [element_width*no_of_eqn_per_cluster-1:0] out_full,
  output logic                                       finish,
  output logic                                       busy,
  output logic                                       overflow,
  output logic                                       pad_error
);

  localparam int N          = no_of_eqn_per_cluster;
  localparam int W          = element_width;
  localparam int U          = no_of_units;
  localparam int ADDITIONAL = NI - (N % NI);
  localparam int TOTAL      = N + ADDITIONAL;
  localparam int CHUNKS     = TOTAL / U;
  localparam int CNT_W      = $clog2(CHUNKS + 1);
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);

  // Handshake: in_valid is a one-cycle strobe qualifying in_data; there is no
  // ready, so every strobe seen in COLLECT with start high is consumed that edge.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] chunk_cnt;
  logic             capture;
  logic             enter_collect;

  assign capture       = (state == COLLECT) && start && in_valid;
  assign enter_collect = (state == IDLE) && start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      chunk_cnt <= '0;
      out_full  <= '0;
      finish    <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= COLLECT;
            busy      <= 1'b1;
            chunk_cnt <= '0;
            out_full  <= '0;
            overflow  <= 1'b0;
          end
        end
        COLLECT: begin
          if (!start) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (in_valid) begin
            // Element e lives in chunk e/U at slot e%U; padding slots are never written.
            for (int e = 0; e < N; e++) begin
              if (chunk_cnt == CNT_W'(e / U))
                out_full[W*(N-e)-1 -: W] <= in_data[W*(U-(e % U))-1 -: W];
            end
            chunk_cnt <= chunk_cnt + 1'b1;
            if (chunk_cnt == LAST_CHUNK) begin
              state  <= DONE;
              busy   <= 1'b0;
              finish <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!start) begin
            state  <= IDLE;
            finish <= 1'b0;
          end else if (in_valid) begin
            overflow <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          finish <= 1'b0;
        end
      endcase
    end
  end

`ifdef COLLECTOR_PAD_CHECK_EN
  logic pad_hit;

  always_comb begin
    pad_hit = 1'b0;
    for (int c = 0; c < CHUNKS; c++) begin
      for (int j = 0; j < U; j++) begin
        if ((c * U + j >= N) && (chunk_cnt == CNT_W'(c)) &&
            (in_data[W*(U-j)-1 -: W] != '0))
          pad_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pad_error <= 1'b0;
    else if (enter_collect)
      pad_error <= 1'b0;
    else if (capture && pad_hit)
      pad_error <= 1'b1;
  end
`else
  logic unused_pad;
  assign unused_pad = capture ^ enter_collect;
  assign pad_error  = 1'b0;
`endif

endmodule

// File: tb/tb_complex_result_collector.sv
// Randomized bench for complex_result_collector against an element-queue reference model.
module tb_complex_result_collector;

  localparam int N     = 3;
  localparam int W     = 64;
  localparam int U     = 4;
  localparam int NI    = 8;
  localparam int TOTAL = N + (NI - (N % NI));
`ifdef COLLECTOR_PAD_CHECK_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic           clk;
  logic           reset;
  logic           start;
  logic           in_valid;
  logic [W*U-1:0] in_data;
  logic [W*N-1:0] out_full;
  logic           finish;
  logic           busy;
  logic           overflow;
  logic           pad_error;

  complex_result_collector #(
    .no_of_eqn_per_cluster(N),
    .element_width(W),
    .no_of_units(U),
    .NI(NI)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .in_data(in_data),
    .in_valid(in_valid),
    .out_full(out_full),
    .finish(finish),
    .busy(busy),
    .overflow(overflow),
    .pad_error(pad_error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model: every received slot is queued in arrival order; the
  // vector is simply the first N queued elements
  logic [W-1:0] exp_q[$];
  bit active, complete;
  bit m_finish, m_busy, m_overflow, m_pad;

  localparam logic [W-1:0] A = 64'h1_0000_0002;
  localparam logic [W-1:0] B = 64'h3_0000_0004;
  localparam logic [W-1:0] C = 64'h5_0000_0006;

  task automatic check(input string tag, input logic [W*N-1:0] obs, input logic [W*N-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W*N-1:0] model_vector();
    logic [W*N-1:0] v;
    v = '0;
    for (int e = 0; e < N; e++)
      if (e < exp_q.size()) v[W*(N-e)-1 -: W] = exp_q[e];
    return v;
  endfunction

  function automatic logic [W*U-1:0] mk(input logic [W-1:0] s0, s1, s2, s3);
    return {s0, s1, s2, s3};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    active = 0; complete = 0;
    m_finish = 0; m_busy = 0; m_overflow = 0; m_pad = 0;
  endtask

  task automatic model_step(input bit s, input bit v, input logic [W*U-1:0] d);
    logic [W-1:0] slot;
    if (!s) begin
      active = 0; complete = 0; m_finish = 0; m_busy = 0;
    end else if (!active) begin
      active = 1; complete = 0; m_busy = 1;
      exp_q.delete(); m_overflow = 0; m_pad = 0;
    end else if (!complete) begin
      if (v) begin
        for (int j = 0; j < U; j++) begin
          slot = d[W*(U-j)-1 -: W];
          if (PAD_EN && exp_q.size() >= N && slot != '0) m_pad = 1;
          exp_q.push_back(slot);
        end
        if (exp_q.size() == TOTAL) begin
          complete = 1; m_finish = 1; m_busy = 0;
        end
      end
    end else if (v) begin
      m_overflow = 1;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".out_full"}, out_full, model_vector());
    check({tag, ".finish"}, {{(W*N-1){1'b0}}, finish}, {{(W*N-1){1'b0}}, m_finish});
    check({tag, ".busy"}, {{(W*N-1){1'b0}}, busy}, {{(W*N-1){1'b0}}, m_busy});
    check({tag, ".overflow"}, {{(W*N-1){1'b0}}, overflow}, {{(W*N-1){1'b0}}, m_overflow});
    check({tag, ".pad_error"}, {{(W*N-1){1'b0}}, pad_error}, {{(W*N-1){1'b0}}, m_pad});
  endtask

  // driver: inputs change 1 time unit after a rising edge, checked 1 unit after the next
  task automatic cycle(input string tag, input bit s, input bit v, input logic [W*U-1:0] d);
    start = s; in_valid = v; in_data = d;
    model_step(s, v, d);
    @(posedge clk); #1;
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all({tag, ".async"});
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
  endtask

  function automatic logic [W*U-1:0] rand_chunk();
    logic [W*U-1:0] d;
    for (int j = 0; j < U; j++)
      d[W*(U-j)-1 -: W] = ($urandom_range(0, 3) == 0) ? '0 : {$urandom, $urandom};
    return d;
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    reset = 1'b0;

    // strobes while idle are ignored
    cycle("idle_strobe", 0, 1, mk(A, B, C, 64'h9));

    // basic collection then overflow
    cycle("basic.enter", 1, 0, '0);
    cycle("basic.c0", 1, 1, mk(A, B, C, '0));
    cycle("basic.c1", 1, 1, mk('0, '0, '0, '0));
    check("basic.vector", out_full, {A, B, C});
    cycle("ovf.strobe", 1, 1, mk(64'hDEAD, 64'hBEEF, 64'h1, 64'h2));
    cycle("ovf.hold", 1, 0, '0);
    cycle("basic.leave", 0, 0, '0);

    // abort after first chunk, then restart
    cycle("abort.enter", 1, 0, '0);
    cycle("abort.c0", 1, 1, mk(C, B, A, '0));
    cycle("abort.drop", 0, 0, '0);
    cycle("abort.idle", 0, 1, mk(A, A, A, A));
    cycle("restart.enter", 1, 0, '0);
    check("restart.cleared", out_full, '0);
    cycle("restart.c0", 1, 1, mk(B, C, A, '0));
    cycle("restart.c1", 1, 1, '0);
    cycle("restart.leave", 0, 0, '0);

    // padding check
    cycle("pad.enter", 1, 0, '0);
    cycle("pad.c0", 1, 1, mk(A, B, C, '0));
    cycle("pad.c1", 1, 1, mk('0, '0, 64'hFF, '0));
    check("pad.vector", out_full, {A, B, C});
    cycle("pad.leave", 0, 0, '0);

    // start falling together with the last strobe
    cycle("simul.enter", 1, 0, '0);
    cycle("simul.c0", 1, 1, mk(A, B, C, '0));
    cycle("simul.c1", 0, 1, '0);
    cycle("simul.idle", 0, 0, '0);

    // async reset during COLLECT
    cycle("areset.enter", 1, 0, '0);
    cycle("areset.c0", 1, 1, mk(C, C, C, '0));
    async_reset("areset");
    cycle("areset.after", 0, 0, '0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        async_reset("rand");
      end else begin
        cycle("rand", ($urandom_range(0, 9) != 0), ($urandom_range(0, 1) == 1), rand_chunk());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
